// File: rtl/srp_buff_reader_pkg.sv
// Shared constants, FSM encoding and beat payload for the SRP sample-buffer reader.
package srp_buff_reader_pkg;

    localparam int unsigned SRP_DEPTH  = 2240;
    localparam int unsigned SRP_ADDR_W = 12;
    localparam int unsigned SRP_DATA_W = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2
    } srp_state_e;

    // One captured byte plus its end-of-request tag
    typedef struct packed {
        logic                  last;
        logic [SRP_DATA_W-1:0] data;
    } srp_beat_t;

    localparam int unsigned SRP_BEAT_W = $bits(srp_beat_t);

    // Ring-buffer address increment, wrapping DEPTH-1 -> 0
    function automatic logic [SRP_ADDR_W-1:0] srp_next_addr(input logic [SRP_ADDR_W-1:0] a);
        return (a == SRP_ADDR_W'(SRP_DEPTH - 1)) ? '0 : a + SRP_ADDR_W'(1);
    endfunction

endpackage

// File: rtl/srp_skid_fifo.sv
// Two-entry FIFO; slot0 is always the head so the output is a plain register.
module srp_skid_fifo #(
    parameter int unsigned W = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic [1:0]   count
);

    logic [W-1:0] slot0_q;
    logic [W-1:0] slot1_q;
    logic [1:0]   count_q;
    logic         pop_ok;
    logic         push_ok;

    assign pop_ok  = pop && (count_q != 2'd0);
    assign push_ok = push && ((count_q != 2'd2) || pop_ok);
    assign dout    = slot0_q;
    assign count   = count_q;

    // Storage update; simultaneous push and pop keeps the count unchanged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot0_q <= '0;
            slot1_q <= '0;
            count_q <= 2'd0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10: begin
                    if (count_q == 2'd0) slot0_q <= din;
                    else                 slot1_q <= din;
                    count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    slot0_q <= slot1_q;
                    count_q <= count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        slot0_q <= din;
                    end else begin
                        slot0_q <= slot1_q;
                        slot1_q <= din;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/srp_buff_reader.sv
// Read-side sequencer: walks the circular sample BRAM and streams bytes out with backpressure.
module srp_buff_reader
    import srp_buff_reader_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [SRP_ADDR_W-1:0] start_addr,
    input  logic [SRP_ADDR_W-1:0] length,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  bram_en,
    output logic                  bram_we,
    output logic [SRP_ADDR_W-1:0] bram_addr,
    input  logic [SRP_DATA_W-1:0] bram_dout,
    output logic [SRP_DATA_W-1:0] m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_tlast
);

    localparam logic [SRP_ADDR_W-1:0] DEPTH_A = SRP_ADDR_W'(SRP_DEPTH);

    srp_state_e            state_q, state_d;
    logic [SRP_ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [SRP_ADDR_W-1:0] remaining_q, remaining_d;
    logic                  done_imm_q, done_imm_d;
    logic                  err_q, err_d;
    logic                  rd_vld_q;
    logic                  rd_last_q;

    srp_beat_t             cap;
    srp_beat_t             head;
    logic [1:0]            fifo_count;
    logic                  pop;
    logic [2:0]            occ;
    logic                  issue;

    // Byte returned by the BRAM one cycle after its read, tagged if it was the final read
    assign cap = '{last: rd_last_q, data: bram_dout};

    srp_skid_fifo #(
        .W (SRP_BEAT_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rd_vld_q),
        .din   (cap),
        .pop   (pop),
        .dout  (head),
        .count (fifo_count)
    );

    assign m_tvalid = (fifo_count != 2'd0);
    assign pop      = m_tvalid && m_tready;

    // Slot accounting counts the beat leaving this cycle so a steady ready stream runs at one byte per cycle
    assign occ   = 3'(rd_vld_q) + 3'(fifo_count) - 3'(pop);
    assign issue = (state_q == S_READ) && (remaining_q != '0) && (occ < 3'd2);

    assign busy      = (state_q != S_IDLE);
    assign done      = done_imm_q || (pop && head.last);
    assign err       = err_q;
    assign bram_en   = issue;
    assign bram_we   = 1'b0;
    assign bram_addr = rd_addr_q;
    assign m_tdata   = head.data;
    assign m_tlast   = m_tvalid && head.last;

    // Next-state, address and remaining-count logic
    always_comb begin
        state_d     = state_q;
        rd_addr_d   = rd_addr_q;
        remaining_d = remaining_q;
        done_imm_d  = 1'b0;
        err_d       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (start_addr >= DEPTH_A) begin
                        done_imm_d = 1'b1;
                        err_d      = 1'b1;
                    end else if (length == '0) begin
                        done_imm_d = 1'b1;
                    end else begin
                        state_d     = S_READ;
                        rd_addr_d   = start_addr;
                        remaining_d = (length > DEPTH_A) ? DEPTH_A : length;
                    end
                end
            end
            S_READ: begin
                if (issue) begin
                    rd_addr_d   = srp_next_addr(rd_addr_q);
                    remaining_d = remaining_q - SRP_ADDR_W'(1);
                    if (remaining_q == SRP_ADDR_W'(1)) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (pop && head.last) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, counters and read-pipeline tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rd_addr_q   <= '0;
            remaining_q <= '0;
            done_imm_q  <= 1'b0;
            err_q       <= 1'b0;
            rd_vld_q    <= 1'b0;
            rd_last_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_addr_q   <= rd_addr_d;
            remaining_q <= remaining_d;
            done_imm_q  <= done_imm_d;
            err_q       <= err_d;
            rd_vld_q    <= issue;
            rd_last_q   <= issue && (remaining_q == SRP_ADDR_W'(1));
        end
    end

endmodule

// File: tb/tb_srp_buff_reader.sv
// Randomized self-checking bench for srp_buff_reader with a behavioural 2240x8 BRAM.
module tb_srp_buff_reader;
    import srp_buff_reader_pkg::*;

    localparam int DEPTH = int'(SRP_DEPTH);

    logic                  clk;
    logic                  rst_n;
    logic                  start;
    logic [SRP_ADDR_W-1:0] start_addr;
    logic [SRP_ADDR_W-1:0] length;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic                  bram_en;
    logic                  bram_we;
    logic [SRP_ADDR_W-1:0] bram_addr;
    logic [SRP_DATA_W-1:0] bram_dout;
    logic [SRP_DATA_W-1:0] m_tdata;
    logic                  m_tvalid;
    logic                  m_tready;
    logic                  m_tlast;

    srp_buff_reader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .length     (length),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .bram_en    (bram_en),
        .bram_we    (bram_we),
        .bram_addr  (bram_addr),
        .bram_dout  (bram_dout),
        .m_tdata    (m_tdata),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .m_tlast    (m_tlast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural BRAM, preloaded with mem[i] = i[7:0], one-cycle read latency
    logic [7:0] mem [DEPTH];
    initial for (int i = 0; i < DEPTH; i++) mem[i] = 8'(i);
    always @(posedge clk) if (bram_en) bram_dout <= mem[bram_addr];

    typedef struct packed {
        logic       l;
        logic [7:0] d;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc = 0;
    int   beats, done_cnt, err_cnt, en_cnt;
    int   first_tv, first_en, done_cyc, first_beat, last_beat, start_cyc;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data;
    logic       prev_last;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Stream monitor: scoreboard against the expected byte queue, plus hold-while-stalled checks
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", m_tvalid, 1);
                check("hold_data", m_tdata, prev_data);
                check("hold_last", m_tlast, prev_last);
            end
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    check("extra_beat", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("tdata", m_tdata, e.d);
                    check("tlast", m_tlast, e.l);
                    check("done_with_last", done, e.l);
                    if (beats == 0) first_beat = cyc;
                    last_beat = cyc;
                end
                beats++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                if (err) err_cnt++;
            end else if (err) begin
                check("err_without_done", 1, 0);
            end
            if (bram_en) begin
                en_cnt++;
                if (first_en < 0) first_en = cyc;
                check("bram_addr_range", 32'(bram_addr < SRP_ADDR_W'(DEPTH)), 1);
            end
            if (m_tvalid && first_tv < 0) first_tv = cyc;
            prev_stall = m_tvalid && !m_tready;
            prev_data  = m_tdata;
            prev_last  = m_tlast;
        end
    end

    task automatic clear_stats();
        beats = 0; done_cnt = 0; err_cnt = 0; en_cnt = 0;
        first_tv = -1; first_en = -1; done_cyc = -1; first_beat = -1; last_beat = -1;
    endtask

    // mode 0: always ready, 1: random ready, 2: ready pattern 1,0,0 repeating
    task automatic drive_ready(input int mode, input int i);
        case (mode)
            0:       m_tready = 1'b1;
            1:       m_tready = ($urandom_range(0, 3) != 0);
            default: m_tready = ((i % 3) == 0);
        endcase
    endtask

    // One request end to end; dup_at > 0 pulses a second start that many cycles in
    task automatic run_req(input string name, input int addr, input int len, input int mode, input int dup_at);
        int  n;
        int  budget;
        bit  exp_err;
        exp_err = (addr >= DEPTH);
        n = exp_err ? 0 : ((len > DEPTH) ? DEPTH : len);
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back('{l: (i == n - 1), d: 8'((addr + i) % DEPTH)});
        clear_stats();
        @(posedge clk); #1;
        start      = 1'b1;
        start_addr = SRP_ADDR_W'(addr);
        length     = SRP_ADDR_W'(len);
        drive_ready(mode, 0);
        start_cyc  = cyc;
        budget     = n * 6 + 20;
        for (int i = 1; i <= budget && done_cnt == 0; i++) begin
            @(posedge clk); #1;
            start = (i == dup_at);
            if (i == dup_at) begin
                start_addr = SRP_ADDR_W'($urandom_range(0, DEPTH - 1));
                length     = SRP_ADDR_W'($urandom_range(1, 30));
            end
            drive_ready(mode, i);
        end
        start = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            m_tready = 1'b1;
        end
        check({name, "_done_count"}, done_cnt, 1);
        check({name, "_beats"}, beats, n);
        check({name, "_left_over"}, exp_q.size(), 0);
        check({name, "_err"}, err_cnt, exp_err ? 1 : 0);
        check({name, "_reads"}, en_cnt, n);
        check({name, "_busy_after"}, busy, 0);
        check({name, "_we"}, bram_we, 0);
        if (n == 0) begin
            check({name, "_imm_done_lat"}, done_cyc - start_cyc, 1);
            check({name, "_no_tvalid"}, first_tv, 32'hffff_ffff);
        end else begin
            check({name, "_first_en_lat"}, first_en - start_cyc, 1);
            check({name, "_first_tv_lat"}, first_tv - start_cyc, 3);
            if (mode == 0) check({name, "_no_bubble"}, last_beat - first_beat, n - 1);
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, l, m;
        rst_n = 1'b0; start = 1'b0; start_addr = '0; length = '0; m_tready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_bram_en", bram_en, 0);
        check("rst_bram_addr", bram_addr, 0);
        check("rst_tvalid", m_tvalid, 0);
        check("rst_tlast", m_tlast, 0);
        check("rst_tdata", m_tdata, 0);
        rst_n = 1'b1;

        run_req("basic", 10, 5, 0, -1);
        run_req("wrap", 2237, 6, 0, -1);
        run_req("toggle", 0, 8, 2, -1);
        run_req("len0", 55, 0, 0, -1);
        run_req("bad_addr", 2300, 7, 0, -1);
        run_req("last_addr", 2239, 1, 0, -1);
        run_req("busy_start", 300, 20, 0, 2);
        run_req("full_ring", 1234, DEPTH, 0, -1);
        run_req("clamped", 7, 4095, 1, -1);

        // Reset in the middle of a transfer
        clear_stats();
        exp_q.delete();
        @(posedge clk); #1;
        start = 1'b1; start_addr = SRP_ADDR_W'(500); length = SRP_ADDR_W'(50); m_tready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_err", err, 0);
        check("mid_rst_bram_en", bram_en, 0);
        check("mid_rst_bram_addr", bram_addr, 0);
        check("mid_rst_tvalid", m_tvalid, 0);
        check("mid_rst_tlast", m_tlast, 0);
        check("mid_rst_tdata", m_tdata, 0);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1; m_tready = 1'b1;
        clear_stats();
        repeat (8) begin @(posedge clk); #1; end
        check("post_rst_beats", beats, 0);
        check("post_rst_reads", en_cnt, 0);
        check("post_rst_done", done_cnt, 0);
        run_req("after_rst", 100, 3, 0, -1);

        // Randomized requests
        for (int r = 0; r < 24; r++) begin
            a = ($urandom_range(0, 5) == 0) ? int'($urandom_range(DEPTH, 4095)) : int'($urandom_range(0, DEPTH - 1));
            l = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 40));
            m = int'($urandom_range(0, 2));
            run_req($sformatf("rand%0d", r), a, l, m, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
